pwm_multi: RTL and testbench

- Multi-channel PWM generator; the parametrised successor of the single-channel PWM block.
- Channels share one period counter, giving phase-aligned edges across channels.
- Each channel has its own duty and output polarity.
- Period and duty are double-buffered and take effect only at a period boundary, so a mid-cycle update cannot produce a runt pulse.
- Drives LED/buzzer/motor outputs from the top-level control logic.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_multi_chan.sv | 49 ++++
 rtl/pwm_multi.sv | 96 +++++++++
 tb/tb_pwm_multi.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and slice helpers for the multi-channel PWM block.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned CHANNELS_MAX = 16;

    // Low bit of channel ch inside the packed duty bus.
    function automatic int unsigned duty_base(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_multi_chan.sv
// One PWM channel: double-buffered duty, compare against the shared counter,
// polarity applied into the output register.
module pwm_chan #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty,
    input  logic             capture,
    input  logic             apply,
    input  logic             run,
    input  logic             polarity,
    output logic             pwm_out
);

    logic [CNT_W-1:0] pending_duty;
    logic [CNT_W-1:0] act_duty;

    // Pending duty follows every update strobe; last write wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_duty <= '0;
        end else if (capture) begin
            pending_duty <= duty;
        end
    end

    // Active duty changes only on the boundary chosen by the top level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_duty <= '0;
        end else if (apply) begin
            act_duty <= pending_duty;
        end
    end

    // Reset forces 0 regardless of polarity; idle drives the inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else if (run) begin
            pwm_out <= (cnt < act_duty) ^ polarity;
        end else begin
            pwm_out <= polarity;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, double-buffered period and
// duties applied at period boundaries (or immediately while idle).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      update,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] pending_period;
    logic             idle_c;
    logic             wrap_c;
    logic             apply_c;

    // A zero period behaves exactly like en=0.
    assign idle_c  = !en || (act_period == '0);
    assign wrap_c  = !idle_c && (cnt == act_period - CNT_W'(1));
    assign apply_c = pending && (idle_c || wrap_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (idle_c || wrap_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_period <= '0;
        end else if (update) begin
            pending_period <= period;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period <= '0;
        end else if (apply_c) begin
            act_period <= pending_period;
        end
    end

    // An update coinciding with an apply keeps pending set for the new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (update) begin
            pending <= 1'b1;
        end else if (apply_c) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_end <= 1'b0;
        end else begin
            period_end <= wrap_c;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam int unsigned LO = duty_base(i, CNT_W);

        pwm_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .cnt      (cnt),
            .duty     (duty[LO +: CNT_W]),
            .capture  (update),
            .apply    (apply_c),
            .run      (!idle_c),
            .polarity (polarity[i]),
            .pwm_out  (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (4 channels, 16-bit counter).
module tb_pwm_multi;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] period;
    logic [63:0] duty;
    logic [3:0]  polarity;
    logic        update;
    logic [3:0]  pwm_out;
    logic        period_end;
    logic        pending;

    int n_cmp = 0;
    int n_err = 0;

    pwm_multi #(.CHANNELS(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period     (period),
        .duty       (duty),
        .polarity   (polarity),
        .update     (update),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for counter value k with the given active duties.
    function automatic logic [3:0] exp_pwm(input int k, input logic [63:0] d, input logic [3:0] pol);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) begin
            r[c] = (k < int'(d[c*16 +: 16])) ^ pol[c];
        end
        return r;
    endfunction

    // Reset, program period/duty while idle, then enable; next tick samples cnt=0.
    task automatic start(input logic [15:0] p, input logic [63:0] d, input logic [3:0] pol);
        en       = 1'b0;
        polarity = pol;
        update   = 1'b0;
        rst      = 1'b1;
        tick();
        rst    = 1'b0;
        period = p;
        duty   = d;
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        en       = 1'b0;
        period   = 16'd0;
        duty     = 64'd0;
        polarity = 4'b0101;
        update   = 1'b1;
        tick();
        n_cmp++;
        if (pwm_out !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pwm got %b exp %b", pwm_out, 4'b0000);
        end
        n_cmp++;
        if (pending !== 1'b0 || period_end !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got pending=%b period_end=%b exp 0 0", pending, period_end);
        end
        rst    = 1'b0;
        update = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== 4'b0101 || period_end !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_reset j=%0d got pwm=%b pe=%b exp 0101 0", j, pwm_out, period_end);
            end
        end
    endtask

    task automatic test_basic_duty();
        logic [63:0] d;
        d = {16'd0, 16'd10, 16'd7, 16'd3};
        start(16'd10, d, 4'b0000);
        for (int j = 0; j < 30; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== {1'b0, 1'b1, (j % 10) < 7, (j % 10) < 3}) begin
                n_err++;
                $display("FAIL basic_pwm j=%0d got %b exp %b", j, pwm_out, exp_pwm(j % 10, d, 4'b0000));
            end
            n_cmp++;
            if (period_end !== ((j % 10) == 9)) begin
                n_err++;
                $display("FAIL basic_period_end j=%0d got %b exp %b", j, period_end, (j % 10) == 9);
            end
        end
    endtask

    task automatic test_glitch_free();
        start(16'd10, 64'd3, 4'b0000);
        for (int j = 0; j < 20; j++) begin
            if (j == 5) begin
                duty   = 64'd8;
                update = 1'b1;
            end
            tick();
            update = 1'b0;
            n_cmp++;
            if (pwm_out[0] !== ((j < 10) ? (j < 3) : ((j - 10) < 8))) begin
                n_err++;
                $display("FAIL glitch_pwm j=%0d got %b exp %b", j, pwm_out[0],
                         (j < 10) ? (j < 3) : ((j - 10) < 8));
            end
            n_cmp++;
            if (pending !== (j >= 5 && j <= 8)) begin
                n_err++;
                $display("FAIL glitch_pending j=%0d got %b exp %b", j, pending, (j >= 5 && j <= 8));
            end
        end
    endtask

    task automatic test_update_on_wrap();
        logic exp_o;
        start(16'd10, 64'd3, 4'b0000);
        for (int j = 0; j < 30; j++) begin
            if (j == 5) begin
                duty   = 64'd8;
                update = 1'b1;
            end
            if (j == 9) begin
                duty   = 64'd6;
                update = 1'b1;
            end
            tick();
            update = 1'b0;
            if (j < 10)      exp_o = (j < 3);
            else if (j < 20) exp_o = ((j - 10) < 8);
            else             exp_o = ((j - 20) < 6);
            n_cmp++;
            if (pwm_out[0] !== exp_o) begin
                n_err++;
                $display("FAIL wrap_pwm j=%0d got %b exp %b", j, pwm_out[0], exp_o);
            end
            n_cmp++;
            if (pending !== (j >= 5 && j <= 18)) begin
                n_err++;
                $display("FAIL wrap_pending j=%0d got %b exp %b", j, pending, (j >= 5 && j <= 18));
            end
        end
    endtask

    task automatic test_polarity_extremes();
        // ch0 duty 0 inverted -> 1; ch1 duty>=period -> 1; ch2 inverted full -> 0; ch3 duty 0 -> 0
        start(16'd10, {16'd0, 16'd12, 16'd10, 16'd0}, 4'b0101);
        for (int j = 0; j < 12; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== 4'b0011) begin
                n_err++;
                $display("FAIL polarity_pwm j=%0d got %b exp %b", j, pwm_out, 4'b0011);
            end
        end
        start(16'd0, {16'd5, 16'd5, 16'd5, 16'd5}, 4'b1001);
        for (int j = 0; j < 12; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== 4'b1001 || period_end !== 1'b0) begin
                n_err++;
                $display("FAIL zero_period j=%0d got pwm=%b pe=%b exp 1001 0", j, pwm_out, period_end);
            end
        end
        // With period 0 the new period applies on the very next edge.
        period = 16'd4;
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        n_cmp++;
        if (pending !== 1'b0) begin
            n_err++;
            $display("FAIL zero_period_apply got pending=%b exp 0", pending);
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== 4'b0110 || period_end !== ((j % 4) == 3)) begin
                n_err++;
                $display("FAIL zero_period_restart j=%0d got pwm=%b pe=%b exp 0110 %b",
                         j, pwm_out, period_end, (j % 4) == 3);
            end
        end
    endtask

    task automatic test_async_reset();
        start(16'd10, {16'd0, 16'd0, 16'd0, 16'd7}, 4'b0000);
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                duty   = 64'd2;
                update = 1'b1;
            end
            tick();
            update = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pwm_out !== 4'b0000 || pending !== 1'b0 || period_end !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got pwm=%b pending=%b pe=%b exp 0000 0 0", pwm_out, pending, period_end);
        end
        tick();
        rst      = 1'b0;
        polarity = 4'b0100;
        period   = 16'd10;
        duty     = 64'd3;
        update   = 1'b1;
        tick();
        update = 1'b0;
        n_cmp++;
        if (pwm_out !== 4'b0100) begin
            n_err++;
            $display("FAIL post_reset_idle got %b exp %b", pwm_out, 4'b0100);
        end
        tick();
        for (int j = 0; j < 12; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== {2'b01, 1'b0, (j % 10) < 3}) begin
                n_err++;
                $display("FAIL restart_pwm j=%0d got %b exp %b", j, pwm_out, {2'b01, 1'b0, (j % 10) < 3});
            end
        end
    endtask

    task automatic test_en_fall();
        start(16'd10, 64'd8, 4'b0010);
        for (int j = 0; j < 4; j++) tick();
        en = 1'b0;
        tick();
        n_cmp++;
        if (pwm_out !== 4'b0010) begin
            n_err++;
            $display("FAIL en_fall_idle got %b exp %b", pwm_out, 4'b0010);
        end
        en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_cmp++;
            if (pwm_out !== {2'b00, 1'b1, j < 8} || period_end !== (j == 9)) begin
                n_err++;
                $display("FAIL en_rise j=%0d got pwm=%b pe=%b exp %b %b", j, pwm_out, period_end,
                         {2'b00, 1'b1, j < 8}, j == 9);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_glitch_free();
        test_update_on_wrap();
        test_polarity_extremes();
        test_async_reset();
        test_en_fall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
